// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_pkg
// Description : State codes, opcodes and instruction fields shared with the
//               output decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package control_sequencer_pkg;

    localparam int c_STATE_BITS = 5;
    localparam int c_INSTR_W    = 24;

    // Instruction word layout
    localparam int c_OPC_HI    = 23;
    localparam int c_OPC_LO    = 20;
    localparam int c_OP1_HI    = 19;
    localparam int c_OP1_LO    = 16;
    localparam int c_OP2_HI    = 15;
    localparam int c_OP2_LO    = 0;
    localparam int c_ALU_OP_HI = 21;
    localparam int c_ALU_OP_LO = 20;

    localparam logic [3:0] OP_LOAD   = 4'h4;
    localparam logic [3:0] OP_MOVE   = 4'h5;
    localparam logic [3:0] OP_LDPC   = 4'h6;
    localparam logic [3:0] OP_BRANCH = 4'h7;
    localparam logic [3:0] OP_MINALL = 4'h8;

    typedef enum logic [c_STATE_BITS-1:0] {
        S_IDLE     = 5'b00000,
        S_FETCH    = 5'b00001,
        S_DECODE   = 5'b00010,
        S_ALU_A    = 5'b00011,
        S_ALU_G    = 5'b00100,
        S_ALU_WB   = 5'b00101,
        S_LOAD     = 5'b00110,
        S_MOVE     = 5'b00111,
        S_LDPC     = 5'b01000,
        S_BRANCH   = 5'b01001,
        S_MIN_INIT = 5'b01010,
        S_MIN_G    = 5'b01011,
        S_MIN_A    = 5'b01100,
        S_MIN_WB   = 5'b01101
    } state_t;

    // Opcodes 0..3 are the ALU group; the low two bits select the operation.
    function automatic logic is_alu_opcode(input logic [3:0] opc);
        return (opc[3:2] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Fetch/decode/execute control FSM with a MINALL register scan.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int         STATE_W  = 5,
    parameter logic [3:0] MIN_LAST = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               instr_valid,
    input  logic [23:0]        instr,
    output logic               instr_ready,
    output logic [STATE_W-1:0] state,
    output logic [23:0]        func,
    output logic [1:0]         alu_op,
    output logic [3:0]         min_idx,
    output logic               illegal,
    output logic               busy
);

    state_t      r_state;
    state_t      w_next;
    logic [23:0] r_func;
    logic [3:0]  r_min_idx;
    logic [3:0]  w_opcode;
    logic        w_accept;
    logic        w_illegal;

    assign w_opcode    = r_func[c_OPC_HI:c_OPC_LO];
    assign instr_ready = (r_state == S_FETCH) && run;
    assign w_accept    = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_accept) begin
                    w_next = S_DECODE;
                end else if (!run) begin
                    w_next = S_IDLE;
                end
            end
            S_DECODE: begin
                if (is_alu_opcode(w_opcode)) begin
                    w_next = S_ALU_A;
                end else begin
                    case (w_opcode)
                        OP_LOAD:   w_next = S_LOAD;
                        OP_MOVE:   w_next = S_MOVE;
                        OP_LDPC:   w_next = S_LDPC;
                        OP_BRANCH: w_next = S_BRANCH;
                        OP_MINALL: w_next = S_MIN_INIT;
                        default: begin
                            w_next    = S_FETCH;
                            w_illegal = 1'b1;
                        end
                    endcase
                end
            end
            S_ALU_A:    w_next = S_ALU_G;
            S_ALU_G:    w_next = S_ALU_WB;
            S_ALU_WB:   w_next = S_FETCH;
            S_LOAD:     w_next = S_FETCH;
            S_MOVE:     w_next = S_FETCH;
            S_LDPC:     w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_MIN_INIT: w_next = S_MIN_G;
            S_MIN_G:    w_next = S_MIN_A;
            // Compare before increment so the index never wraps past MIN_LAST.
            S_MIN_A:    w_next = (r_min_idx == MIN_LAST) ? S_MIN_WB : S_MIN_G;
            S_MIN_WB:   w_next = S_FETCH;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_func    <= '0;
            r_min_idx <= '0;
        end else begin
            if (w_accept) begin
                r_func <= instr;
            end
            if (r_state == S_MIN_INIT) begin
                r_min_idx <= 4'd1;
            end else if ((r_state == S_MIN_A) && (r_min_idx != MIN_LAST)) begin
                r_min_idx <= r_min_idx + 4'd1;
            end
        end
    end

    assign state   = STATE_W'(r_state);
    assign func    = r_func;
    assign alu_op  = r_func[c_ALU_OP_HI:c_ALU_OP_LO];
    assign min_idx = r_min_idx;
    assign illegal = w_illegal;
    assign busy    = (r_state != S_IDLE) && (r_state != S_FETCH);

endmodule
`default_nettype wire
